// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: link-layer FSM states, frame geometry and the
// odd-parity/frame helpers used by both the transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ps2_state_t;

  localparam int FRAME_BITS = 11;
  localparam int BIT_IDX_W  = 4;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Odd parity: the nine data+parity bits always contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Bit 0 leaves the wire first: start, data LSB first, parity, stop.
  function automatic frame_t make_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous single-clock byte FIFO with a registered occupancy count;
// reads are from the head entry, with no write-to-read bypass.
module ps2_tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic [7:0]    rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses the write even when a pop frees a slot this cycle.
  assign do_wr   = wr_req && !full;
  assign do_rd   = rd_req && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define validity, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_tx.sv
// PS/2 device-to-host transmitter: a byte FIFO feeding an 11-bit frame
// shifter that generates ps2_clk/ps2_data with an idle gap between frames.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 50,
  parameter int GAP_CYCLES  = 200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0]     GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(FRAME_BITS - 1);

  ps2_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic                 low_half;
  frame_t               frame;

  logic [7:0] fifo_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  assign pop      = (state == IDLE) && !fifo_empty;
  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (in_data),
    .wr_req  (in_valid),
    .rd_req  (pop),
    .rd_data (fifo_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Outputs are registered from the current state, so the wire lags the FSM by
  // one cycle: the start bit appears the edge after the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      low_half <= 1'b0;
      frame    <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (pop) begin
            state    <= SHIFT;
            frame    <= make_frame(fifo_data);
            cnt      <= '0;
            bit_idx  <= '0;
            low_half <= 1'b0;
          end
        end

        SHIFT: begin
          // Data only moves at a bit boundary, which is always a high half.
          ps2_clk  <= !low_half;
          ps2_data <= frame[0];
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!low_half) begin
              low_half <= 1'b1;
            end else begin
              low_half <= 1'b0;
              frame    <= {1'b1, frame[FRAME_BITS-1:1]};
              if (bit_idx == LAST_BIT) begin
                state   <= GAP;
                bit_idx <= '0;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bit_idx  <= '0;
          low_half <= 1'b0;
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: host-side bit capture, frame timing, FIFO
// flow control, mid-frame reset and a continuous clock/data protocol checker.
module tb_ps2_tx;

  localparam int HP    = 4;
  localparam int GAP   = 6;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [3:0] fifo_count;

  int errors = 0;
  int checks = 0;

  logic bits_q [$];
  int   span_q [$];
  int   gap_q  [$];

  ps2_tx #(
    .HALF_PERIOD (HP),
    .GAP_CYCLES  (GAP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on the DUT", name);
  endtask

  // Host-side monitor: samples on each falling ps2_clk, measures frame span
  // (start bit to last low cycle) and idle-high gap before each start bit.
  initial begin
    int   cyc = 0;
    int   last_low = -1;
    int   start_cyc = 0;
    int   falls = 0;
    logic prev_clk = 1'b1;
    logic prev_data = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        falls    = 0;
        last_low = -1;
      end else begin
        if (ps2_data !== prev_data) check("proto_data_change_clk_low", ps2_clk, 1'b1);
        if (prev_data === 1'b1 && ps2_data === 1'b0 && ps2_clk === 1'b1 && falls == 0) begin
          start_cyc = cyc;
          if (last_low >= 0) gap_q.push_back(cyc - last_low - 1);
        end
        if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
          bits_q.push_back(ps2_data);
          falls++;
        end
        if (ps2_clk === 1'b0) last_low = cyc;
        if (prev_clk === 1'b0 && ps2_clk === 1'b1 && falls == 11) begin
          span_q.push_back(last_low - start_cyc + 1);
          falls = 0;
        end
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic write_byte(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_frame(output logic [10:0] f, output int span);
    int n = 0;
    f    = 'x;
    span = -1;
    while (span_q.size() == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (span_q.size() == 0) begin
      timeout("frame_capture");
    end else begin
      span = span_q.pop_front();
      for (int i = 0; i < 11; i++) f[i] = (bits_q.size() > 0) ? bits_q.pop_front() : 1'bx;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("return_to_idle", busy, 1'b0);
  endtask

  task automatic clear_queues();
    bits_q.delete();
    span_q.delete();
    gap_q.delete();
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;   // bit i = i-th bit sampled by the host
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [10:0] f, f2;
    int          span, span2;
    int          accepted, first_low, n, n_bits;
    logic [7:0]  order_exp [5];

    // {stop, parity, data[7:0], start}
    vecs[0] = '{8'h1C, 11'b1_0_00011100_0};
    vecs[1] = '{8'hF0, 11'b1_1_11110000_0};
    vecs[2] = '{8'h00, 11'b1_1_00000000_0};
    vecs[3] = '{8'hFF, 11'b1_1_11111111_0};
    vecs[4] = '{8'h01, 11'b1_0_00000001_0};
    vecs[5] = '{8'hA5, 11'b1_1_10100101_0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ps2_clk", ps2_clk, 1'b1);
    check("reset_ps2_data", ps2_data, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_fifo_count", fifo_count, 4'd0);

    // Single frames from idle: pop latency, host-sampled bits, 22*HP span.
    for (int i = 0; i < 6; i++) begin
      clear_queues();
      write_byte(vecs[i].data);
      check($sformatf("v%0d_count_after_write", i), fifo_count, 4'd1);
      check($sformatf("v%0d_idle_at_write", i), ps2_data, 1'b1);
      @(negedge clk);
      check($sformatf("v%0d_popped", i), fifo_count, 4'd0);
      check($sformatf("v%0d_busy", i), busy, 1'b1);
      check($sformatf("v%0d_no_start_yet", i), ps2_data, 1'b1);
      @(negedge clk);
      check($sformatf("v%0d_start_bit", i), {ps2_clk, ps2_data}, 2'b10);
      get_frame(f, span);
      check($sformatf("v%0d_frame", i), f, vecs[i].frame);
      check($sformatf("v%0d_span", i), span, 88);
      wait_idle();
    end

    // Back-to-back writes: order, parity and inter-frame gap.
    clear_queues();
    write_byte(8'hF0);
    write_byte(8'h1C);
    get_frame(f, span);
    get_frame(f2, span2);
    check("b2b_first_frame", f, 11'b1_1_11110000_0);
    check("b2b_second_frame", f2, 11'b1_0_00011100_0);
    check("b2b_first_span", span, 88);
    check("b2b_second_span", span2, 88);
    check("b2b_gap_entries", gap_q.size(), 2);
    if (gap_q.size() > 0) check("b2b_gap_cycles", gap_q[gap_q.size()-1], GAP + 1);
    wait_idle();

    // in_valid held 12 cycles from idle: one byte pops at once, eight fill the FIFO.
    clear_queues();
    accepted  = 0;
    first_low = -1;
    for (int i = 0; i < 12; i++) begin
      in_data  = 8'h40 + 8'(i);
      in_valid = 1'b1;
      if (in_ready) accepted++;
      else if (first_low < 0) first_low = i;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("fill_accepted", accepted, 9);
    check("fill_first_not_ready", first_low, 9);
    check("fill_count", fifo_count, 4'd8);
    check("fill_in_ready", in_ready, 1'b0);

    // Reset during bit 5 of the frame now on the wire.
    n = 0;
    while (bits_q.size() < 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (bits_q.size() < 6) timeout("bit5_wait");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ps2_clk", ps2_clk, 1'b1);
    check("midrst_ps2_data", ps2_data, 1'b1);
    check("midrst_fifo_count", fifo_count, 4'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    n_bits = bits_q.size();
    repeat (100) @(negedge clk);
    check("midrst_no_more_falls", bits_q.size(), n_bits);
    check("midrst_stays_idle", busy, 1'b0);

    // Push on the exact pop edge with three queued bytes.
    clear_queues();
    order_exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    write_byte(8'h12);
    write_byte(8'h34);
    write_byte(8'h56);
    write_byte(8'h78);
    check("pp_count_queued", fifo_count, 4'd3);
    repeat (22*HP + GAP - 2) @(negedge clk);
    check("pp_count_before_pop", fifo_count, 4'd3);
    check("pp_idle_before_pop", {ps2_clk, ps2_data}, 2'b11);
    write_byte(8'h9A);
    check("pp_count_after_push_pop", fifo_count, 4'd3);
    @(negedge clk);
    check("pp_next_start_bit", {ps2_clk, ps2_data}, 2'b10);
    for (int i = 0; i < 5; i++) begin
      get_frame(f, span);
      check($sformatf("pp_order_%0d", i), f[8:1], order_exp[i]);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 50, clk cycles per ps2_clk half-period (≥2).
REQ-002 SHALL have parameter GAP_CYCLES, default 200, idle clk cycles after each frame's stop bit (≥1).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, byte FIFO entries (power of 2, ≥2).
REQ-004 SHALL have port clk  input  1  single clock; every register is updated on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_data  input  8  byte (scan code) to send.
REQ-007 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept; equals !full, combinational from count only.
REQ-009 SHALL have port ps2_clk  output  1  PS/2 clock driven toward the host, registered.
REQ-010 SHALL have port ps2_data  output  1  PS/2 data driven toward the host, registered.
REQ-011 SHALL have port busy  output  1  high when FSM is not IDLE or FIFO not empty.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently held.

Function
REQ-013 SHALL accept a byte on an edge where in_valid && in_ready; when full, no write occurs even if a pop happens the same cycle.
REQ-014 SHALL pop one byte when FSM is IDLE and FIFO non-empty; push and pop in the same cycle leave fifo_count unchanged.
REQ-015 SHALL use FSM states IDLE, SHIFT, GAP: IDLE->SHIFT on pop; SHIFT->GAP after bit 10 low half; GAP->IDLE after GAP_CYCLES.
REQ-016 SHALL form an 11-bit frame on pop: start 0, data bits 0..7 LSB first, odd parity (~^data), stop 1.
REQ-017 SHALL per bit drive ps2_data with the bit and ps2_clk high for HALF_PERIOD cycles, then ps2_clk low for HALF_PERIOD cycles with ps2_data held.
REQ-018 SHALL change ps2_data only while ps2_clk is high; host samples on ps2_clk falling edge.
REQ-019 SHALL make one frame occupy exactly 22*HALF_PERIOD cycles in SHIFT, then hold ps2_clk=1, ps2_data=1 in GAP and IDLE.
REQ-020 SHALL, for a write at edge t into an empty FIFO with FSM IDLE, pop at edge t+1 and show ps2_data=0 (start) after edge t+2.
REQ-021 SHALL send queued bytes in write order with exactly GAP_CYCLES+1 idle-high cycles between one frame's last low half and the next start bit.
REQ-022 SHALL use a HALF_PERIOD counter and a 4-bit bit index 0..10; both reset to 0 on every state entry.

Reset
REQ-023 SHALL, with rst high at an edge (including mid-frame), set FSM IDLE, empty FIFO, fifo_count=0, counters 0.
REQ-024 SHALL drive ps2_clk=1, ps2_data=1, busy=0, in_ready=1 after any reset edge; the aborted frame is never resumed.

Structure
REQ-025 SHALL place FSM state enum, frame length (11) and parity helper in shared package ps2_pkg, reused by the keyboard receiver.
REQ-026 SHALL implement the FIFO as sub-module ps2_tx_fifo (sync, one clock, registered count, no bypass); FSM and shifter stay in ps2_tx.

Verification
REQ-027 SHALL cover: write 0x1C, HALF_PERIOD=4 -> host-sampled bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0); frame spans 88 cycles.
REQ-028 SHALL cover: write 0xF0 then 0x1C back-to-back -> frames in order, 0xF0 parity 1, gap exactly GAP_CYCLES+1 high cycles.
REQ-029 SHALL cover: in_valid held 12 cycles from idle, DEPTH=8 -> exactly 9 bytes accepted, in_ready low from cycle 9, fifo_count=8.
REQ-030 SHALL cover: rst pulsed during bit 5 of a frame -> next edge ps2_clk=1, ps2_data=1, fifo_count=0, no further falling ps2_clk.
REQ-031 SHALL cover: push at the same edge as pop with count=3 -> fifo_count stays 3; data order preserved.
REQ-032 SHALL cover: bench-wide check -> ps2_data never toggles while ps2_clk=0 (protocol checker on every cycle).
